// File: rtl/lighthouse_pulse_decoder.sv
// Lighthouse v1 pulse decoder: sync/sweep classification and sweep timing.
// Optional glitch rejection of short pulses: define LH_GLITCH_FILTER_EN.
module lighthouse_pulse_decoder #(
    parameter int unsigned SYNC_BASE    = 1834,
    parameter int unsigned SYNC_STEP    = 333,
    parameter int unsigned SWEEP_MAX_W  = 1000,
    parameter int unsigned SWEEP_WINDOW = 266667,
    parameter int unsigned MIN_PULSE    = 4,
    parameter logic [19:0] TS_INIT      = '0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        envelope,
    output logic        sweep_valid,
    output logic [19:0] sweep_duration,
    output logic        sweep_axis,
    output logic        ootx_valid,
    output logic        ootx_bit,
    output logic        sync_skip
);

`ifdef LH_GLITCH_FILTER_EN
    localparam logic FILT_EN = 1'b1;
`else
    localparam logic FILT_EN = 1'b0;
`endif

    typedef enum logic {IDLE, ARMED} state_t;

    state_t      state_q;
    state_t      state_d;

    logic        env_m;
    logic        env_s;
    logic        env_d;
    logic [1:0]  warm;
    logic        live;
    logic        rise;
    logic        fall;

    logic [19:0] timestamp;
    logic [19:0] pulse_rise_ts;
    logic [19:0] prev_rise_ts;
    logic [19:0] ref_ts;
    logic        ref_axis;

    logic [11:0] width;
    logic [11:0] cls_w;
    logic        cls_pend;

    logic [31:0] wx;
    logic        is_sweep;
    logic        is_sync;
    logic        glitch;
    logic [2:0]  k;

    logic [19:0] age;
    logic [19:0] sw_off;
    logic        timeout;
    logic        armed;
    logic        ev_sync;
    logic        ev_sweep;
    logic        ld_ref;
    logic        emit_sw;
    logic        emit_ootx;

    // A pulse already high out of reset has no rising edge; wait for low.
    assign rise = live & env_s & ~env_d;
    assign fall = live & ~env_s & env_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            env_m     <= 1'b0;
            env_s     <= 1'b0;
            env_d     <= 1'b0;
            warm      <= 2'b00;
            live      <= 1'b0;
            timestamp <= TS_INIT;
            width     <= '0;
            cls_w     <= '0;
            cls_pend  <= 1'b0;
        end else begin
            env_m     <= envelope;
            env_s     <= env_m;
            env_d     <= env_s;
            warm      <= {warm[0], 1'b1};
            live      <= live | (warm[1] & ~env_s);
            timestamp <= timestamp + 20'd1;
            if (rise) begin
                width <= 12'd1;
            end else if (env_s && width != 12'hFFF) begin
                width <= width + 12'd1;
            end
            cls_pend <= fall;
            if (fall) begin
                cls_w <= width;
            end
        end
    end

    assign wx = 32'(cls_w);

    always_comb begin
        is_sweep = 1'b0;
        is_sync  = 1'b0;
        k        = 3'd0;
        glitch   = FILT_EN & (wx < MIN_PULSE);
        if (!glitch) begin
            if (wx < SWEEP_MAX_W) begin
                is_sweep = 1'b1;
            end else begin
                for (int unsigned i = 0; i < 8; i++) begin
                    if (wx >= SYNC_BASE + i * SYNC_STEP &&
                        wx < SYNC_BASE + (i + 1) * SYNC_STEP) begin
                        is_sync = 1'b1;
                        k       = 3'(i);
                    end
                end
            end
        end
    end

    assign age      = timestamp - ref_ts;
    assign sw_off   = pulse_rise_ts - ref_ts;
    assign timeout  = (state_q == ARMED) && (32'(age) > SWEEP_WINDOW);
    assign armed    = (state_q == ARMED) && !timeout;
    assign ev_sync  = cls_pend & is_sync;
    assign ev_sweep = cls_pend & is_sweep;

    // Timeout is resolved before the pending pulse is acted on.
    always_comb begin
        state_d   = timeout ? IDLE : state_q;
        ld_ref    = 1'b0;
        emit_sw   = 1'b0;
        emit_ootx = 1'b0;
        unique case (1'b1)
            ev_sync: begin
                emit_ootx = 1'b1;
                if (!k[2]) begin
                    ld_ref  = 1'b1;
                    state_d = ARMED;
                end
            end
            ev_sweep: begin
                if (armed) begin
                    state_d = IDLE;
                    emit_sw = (32'(sw_off) <= SWEEP_WINDOW);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pulse_rise_ts  <= '0;
            prev_rise_ts   <= '0;
            ref_ts         <= '0;
            ref_axis       <= 1'b0;
            sweep_valid    <= 1'b0;
            sweep_duration <= '0;
            sweep_axis     <= 1'b0;
            ootx_valid     <= 1'b0;
            ootx_bit       <= 1'b0;
            sync_skip      <= 1'b0;
        end else begin
            if (rise) begin
                prev_rise_ts  <= pulse_rise_ts;
                pulse_rise_ts <= timestamp;
            end else if (cls_pend && glitch) begin
                pulse_rise_ts <= prev_rise_ts;
            end
            if (ld_ref) begin
                ref_ts   <= pulse_rise_ts;
                ref_axis <= k[0];
            end
            sweep_valid <= emit_sw;
            if (emit_sw) begin
                sweep_duration <= sw_off + 20'(cls_w[11:1]);
                sweep_axis     <= ref_axis;
            end
            ootx_valid <= emit_ootx;
            if (emit_ootx) begin
                ootx_bit  <= k[1];
                sync_skip <= k[2];
            end
        end
    end

endmodule

// File: tb/tb_lighthouse_pulse_decoder.sv
// Scoreboard bench for lighthouse_pulse_decoder with an event-level model.
// Window shortened and timestamp preset near wrap to keep runs short.
module tb_lighthouse_pulse_decoder;

    localparam int WIN = 8000;
    localparam int T_SYNC_BASE = 1834;
    localparam int T_SYNC_STEP = 333;
    localparam int T_SWEEP_MAX = 1000;
    localparam int T_MIN = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        envelope = 1'b0;
    logic        sweep_valid;
    logic [19:0] sweep_duration;
    logic        sweep_axis;
    logic        ootx_valid;
    logic        ootx_bit;
    logic        sync_skip;

    lighthouse_pulse_decoder #(
        .SWEEP_WINDOW(WIN),
        .TS_INIT     (20'd1046000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .envelope      (envelope),
        .sweep_valid   (sweep_valid),
        .sweep_duration(sweep_duration),
        .sweep_axis    (sweep_axis),
        .ootx_valid    (ootx_valid),
        .ootx_bit      (ootx_bit),
        .sync_skip     (sync_skip)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_sweep;
        logic [19:0] dur;
        logic        axis;
        logic        obit;
        logic        skip;
        int          at;
    } exp_t;

    exp_t q[$];

    int cyc = 0;
    int compared = 0;
    int mism = 0;

    bit m_armed = 0;
    int m_ref = 0;
    bit m_axis = 0;
    logic [19:0] last_dur = '0;
    logic        last_axis = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Pulse rules applied at the moment the pulse ends.
    task automatic model(input int n, input int r, input int f);
        int   w;
        exp_t e;
        w = (n > 4095) ? 4095 : n;
        if (m_armed && (f - m_ref) > WIN) m_armed = 0;
`ifdef LH_GLITCH_FILTER_EN
        if (w < T_MIN) return;
`endif
        if (w < T_SWEEP_MAX) begin
            if (m_armed) begin
                m_armed = 0;
                if (r - m_ref <= WIN) begin
                    e.is_sweep = 1;
                    e.dur      = 20'((r - m_ref) + w / 2);
                    e.axis     = m_axis;
                    e.obit     = 0;
                    e.skip     = 0;
                    e.at       = f + 4;
                    q.push_back(e);
                end
            end
        end else begin
            for (int c = 0; c < 8; c++) begin
                if (w >= T_SYNC_BASE + c * T_SYNC_STEP &&
                    w < T_SYNC_BASE + (c + 1) * T_SYNC_STEP) begin
                    e.is_sweep = 0;
                    e.dur      = '0;
                    e.axis     = 0;
                    e.obit     = (c / 2) % 2;
                    e.skip     = c / 4;
                    e.at       = f + 4;
                    q.push_back(e);
                    if (c < 4) begin
                        m_armed = 1;
                        m_ref   = r;
                        m_axis  = c % 2;
                    end
                end
            end
        end
    endtask

    task automatic pulse(input int n, input int gap);
        int r;
        int f;
        @(negedge clk);
        envelope = 1'b1;
        r = cyc;
        repeat (n) @(negedge clk);
        envelope = 1'b0;
        f = cyc;
        model(n, r, f);
        repeat (gap) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (sweep_valid || ootx_valid)) begin
            if (sweep_valid && ootx_valid) begin
                compared++;
                mism++;
                $display("FAIL both_strobes: got 1 expected 0 (cycle %0d)", cyc);
            end else if (q.size() == 0) begin
                compared++;
                mism++;
                $display("FAIL unexpected_strobe: sweep=%0d ootx=%0d expected none (cycle %0d)",
                         sweep_valid, ootx_valid, cyc);
            end else begin
                e = q.pop_front();
                chk("strobe_kind", 32'(sweep_valid), 32'(e.is_sweep));
                chk("latency_cycle", cyc, e.at);
                if (e.is_sweep) begin
                    chk("sweep_duration", 32'(sweep_duration), 32'(e.dur));
                    chk("sweep_axis", 32'(sweep_axis), 32'(e.axis));
                    last_dur  = e.dur;
                    last_axis = e.axis;
                end else begin
                    chk("ootx_bit", 32'(ootx_bit), 32'(e.obit));
                    chk("sync_skip", 32'(sync_skip), 32'(e.skip));
                    chk("dur_hold", 32'(sweep_duration), 32'(last_dur));
                    chk("axis_hold", 32'(sweep_axis), 32'(last_axis));
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            envelope = ~envelope;
            chk("rst_sweep_valid", 32'(sweep_valid), 0);
            chk("rst_sweep_duration", 32'(sweep_duration), 0);
            chk("rst_sweep_axis", 32'(sweep_axis), 0);
            chk("rst_ootx_valid", 32'(ootx_valid), 0);
            chk("rst_ootx_bit", 32'(ootx_bit), 0);
            chk("rst_sync_skip", 32'(sync_skip), 0);
        end
        @(negedge clk);
        envelope = 1'b1;
        reset_n  = 1'b1;
        repeat (2000) @(negedge clk);
        envelope = 1'b0;
        repeat (100) @(negedge clk);

        // class 0 sync, sweep 5000 later across the timestamp wrap
        pulse(2000, 3000);
        pulse(300, 500);
        // class 2 sync (data 1, axis 0), then a sweep to expose the axis
        pulse(2700, 300);
        pulse(100, 500);
        // class 1 sync, sweep at +3000, a second sweep is ignored
        pulse(2333, 667);
        pulse(200, 500);
        pulse(200, 500);
        // skip sync alone does not arm
        pulse(3200, 500);
        pulse(200, 500);
        // sweep beyond the window, then nothing further
        pulse(2000, 7000);
        pulse(200, 500);
        pulse(200, 500);
        // 2-cycle pulse between sync and sweep
        pulse(2000, 500);
        pulse(2, 498);
        pulse(200, 500);

        for (int rd = 0; rd < 4; rd++) begin
            int c;
            int n;
            int off;
            int gl;
            bit in_win;
            c = int'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) n = int'($urandom_range(1000, 1833));
            else n = T_SYNC_BASE + c * T_SYNC_STEP + int'($urandom_range(0, 332));
            in_win = ($urandom_range(0, 3) != 0);
            if (in_win) off = int'($urandom_range(n + 300, 6500));
            else off = int'($urandom_range(8300, 8800));
            if (in_win && $urandom_range(0, 2) == 0) begin
                gl = int'($urandom_range(1, 3));
                pulse(n, 50);
                pulse(gl, off - n - 50 - gl);
            end else begin
                pulse(n, off - n);
            end
            pulse(int'($urandom_range(10, 999)), 200);
        end

        repeat (50) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule

// File: doc/lighthouse_pulse_decoder.md
# lighthouse_pulse_decoder

Consumes the conditioned envelope output of the TS4231 light-sensor front end. Classifies each light pulse as a Lighthouse v1 sync pulse or a laser sweep pulse. For every valid sweep, reports the sweep-centre time relative to the start of the governing sync pulse, together with the axis. Sits directly downstream of the ts4231 configuration/interface block (one instance per sensor) and feeds the sensor-data packetiser that drives the SPI/ESP link.

## Interface
Parameters:
- SYNC_BASE, 1834: lower width bound (clk cycles) of sync class 0 (62.5 µs − 5.2 µs at 32 MHz).
- SYNC_STEP, 333: width increment per sync class (10.4 µs).
- SWEEP_MAX_W, 1000: pulses narrower than this are sweeps.
- SWEEP_WINDOW, 266667: max cycles from sync rise to sweep rise (8.33 ms).
- MIN_PULSE, 4: glitch threshold, used only with the filter macro.

Ports:
- clk  in  1  system clock, 32 MHz (CLK32MHz domain).
- reset_n  in  1  synchronous, active-low reset.
- envelope  in  1  asynchronous TS4231 envelope; high = light detected.
- sweep_valid  out  1  one-cycle strobe: sweep result valid.
- sweep_duration  out  20  cycles from sync rise to sweep centre.
- sweep_axis  out  1  axis of the governing sync (0 = horizontal, 1 = vertical).
- ootx_valid  out  1  one-cycle strobe per decoded sync pulse.
- ootx_bit  out  1  data bit of that sync pulse.
- sync_skip  out  1  skip bit of that sync pulse (valid with ootx_valid).

## Operation
- envelope passes through a 2-FF synchroniser to give env_s. Rising and falling edges are detected on env_s versus its previous value.
- A free-running 20-bit timestamp counter wraps modulo 2^20.
- Width counter, 12 bits:
  - cleared to 1 on the env_s rising edge;
  - increments while env_s is high;
  - saturates at 4095.
- The timestamp is latched on each rising edge as pulse_rise_ts.
- On a falling edge, classify width W:
  - W < SWEEP_MAX_W: sweep.
  - SYNC_BASE + k·SYNC_STEP ≤ W < SYNC_BASE + (k+1)·SYNC_STEP, k = 0..7: sync class k, with skip = k[2], data = k[1], axis = k[0]. Class bounds are constant comparisons; no divider.
  - Anything else is discarded with no outputs.
- FSM, two states:
  - IDLE: a sync with skip=0 latches ref_ts = pulse_rise_ts and ref_axis, then goes to ARMED. Sweeps are ignored.
  - ARMED:
    - A sync with skip=0 re-latches ref_ts and ref_axis and stays in ARMED.
    - A sync with skip=1 changes nothing.
    - A sweep with (pulse_rise_ts − ref_ts) mod 2^20 ≤ SWEEP_WINDOW emits sweep_duration = (pulse_rise_ts − ref_ts) + (W >> 1), mod 2^20, with sweep_axis = ref_axis, then goes to IDLE.
    - A sweep outside the window is discarded and the FSM goes to IDLE.
    - Timeout: if (timestamp − ref_ts) > SWEEP_WINDOW, go to IDLE.
- Every classified sync pulse, skip 0 or 1, in either state, asserts ootx_valid with ootx_bit and sync_skip.

## Timing
- Reset: all outputs 0, FSM in IDLE, width counter 0, synchroniser flops 0, timestamp 0.
- A reset asserted mid-pulse aborts the measurement. A pulse already high when reset releases is not measured, because no rising edge is seen.
- Latency: sweep_valid and ootx_valid assert exactly 3 clk after the first clk edge that samples envelope low (2 synchroniser + 1 classify/register). Each strobe is high for exactly 1 cycle.
- sweep_duration, sweep_axis, ootx_bit and sync_skip hold their values until the next strobe of their group.
- Width measurement: a raw high of N sampled cycles yields W = N.
- A rising edge in the same cycle as the timeout check: the timeout is applied first, then the new pulse starts normally.
- sweep_valid and ootx_valid never assert in the same cycle.

## Configuration
- LH_GLITCH_FILTER_EN defined: pulses with W < MIN_PULSE are discarded. They do not touch FSM, ref_ts or outputs. pulse_rise_ts is restored to the previous value, so a glitch cannot corrupt the reference.
- Undefined: every pulse with W ≥ 1 is classified; a 1-cycle pulse counts as a sweep.

## Test plan
- Reset: hold reset_n=0 for 5 cycles while toggling envelope -> all outputs 0. A 2000-cycle pulse started before release produces no strobe.
- Sync class: 2000-cycle pulse -> ootx_valid with ootx_bit=0, sync_skip=0, 3 cycles after fall. A 2700-cycle pulse -> class 2, ootx_bit=1, axis 0.
- Sweep: sync of 2333 cycles (class 1, axis 1) rising at t0, then a 200-cycle sweep rising at t0+100000 -> sweep_valid with sweep_duration=100100 and sweep_axis=1. A second sweep afterwards produces nothing.
- Skip/window: skip=1 sync (W=3200) only -> ootx_valid with sync_skip=1 and no sweep output. With an armed sync and a sweep at t0+300000 -> no sweep_valid, FSM returns to IDLE.
- Wrap: timestamp preloaded so that t0=1048000 and the sweep rises 5000 cycles later -> sweep_duration=5000+W/2 with correct modulo.
- Glitch (macro on): a 2-cycle pulse between sync and sweep -> ignored, sweep result unchanged. With the macro off, the same pulse is consumed as the sweep, with duration = its offset + 1.
